mic_energy_accumulator: RTL and testbench

Upstream feeder for direction_calculator. Takes one signed PCM sample per mic (central plus peripheral ring) on each sample strobe. Accumulates squared amplitude over a fixed window of 2^WINDOW_LOG2 samples. Emits per-mic mean-square energy as unsigned 32-bit words with a one-cycle valid pulse; these words drive direction_calculator's central_mic / peripheral_mics inputs directly.

---
 rtl/mic_energy_if.sv | 25 ++
 rtl/mic_energy_accumulator.sv | 136 +++++++++++++
 tb/tb_mic_energy_accumulator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mic_energy_if.sv
// Sample-in / energy-out bundle for mic_energy_accumulator.
// The slave side is the accumulator; the master side is the sample source / energy consumer.
interface mic_energy_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int NUM_PERIPH   = 3,
    parameter int WINDOW_LOG2  = 10
);
    logic                                     sample_valid_in;
    logic [SAMPLE_WIDTH-1:0]                  central_sample_in;
    logic [NUM_PERIPH-1:0][SAMPLE_WIDTH-1:0]  peripheral_samples_in;
    logic [31:0]                              central_energy_out;
    logic [NUM_PERIPH-1:0][31:0]              peripheral_energy_out;
    logic                                     energy_valid_out;
    logic [WINDOW_LOG2-1:0]                   window_count_out;

    modport master (
        output sample_valid_in, central_sample_in, peripheral_samples_in,
        input  central_energy_out, peripheral_energy_out, energy_valid_out, window_count_out
    );

    modport slave (
        input  sample_valid_in, central_sample_in, peripheral_samples_in,
        output central_energy_out, peripheral_energy_out, energy_valid_out, window_count_out
    );
endinterface

// File: rtl/mic_energy_accumulator.sv
// Per-mic mean-square energy over 2^WINDOW_LOG2 samples, two-stage pipeline (square, accumulate).
// Optional MIC_DC_BLOCK_EN: subtract a per-mic running DC estimate before squaring.
module mic_energy_accumulator #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int NUM_PERIPH   = 3,
    parameter int WINDOW_LOG2  = 10
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    mic_energy_if.slave bus
);
    localparam int NUM_MICS = NUM_PERIPH + 1;
`ifdef MIC_DC_BLOCK_EN
    localparam int D_W = SAMPLE_WIDTH + 1;
`else
    localparam int D_W = SAMPLE_WIDTH;
`endif
    localparam int SQ_W  = 2 * D_W;
    localparam int ACC_W = SQ_W + WINDOW_LOG2;
    localparam logic [WINDOW_LOG2-1:0] LAST = '1;

    function automatic logic [SQ_W-1:0] square(input logic signed [D_W-1:0] d);
        logic signed [SQ_W-1:0] prod;
        prod = SQ_W'(d) * SQ_W'(d);
        return prod;
    endfunction

    function automatic logic [31:0] sat_energy(input logic [ACC_W-1:0] total);
        logic [ACC_W+31:0] mean;
        mean = {32'd0, total >> WINDOW_LOG2};
        if (mean[ACC_W+31:32] != '0) return 32'hFFFF_FFFF;
        return mean[31:0];
    endfunction

    logic signed [SAMPLE_WIDTH-1:0] x_in [NUM_MICS];
    logic signed [D_W-1:0]          d_in [NUM_MICS];

    always_comb begin
        x_in[0] = $signed(bus.central_sample_in);
        for (int m = 0; m < NUM_PERIPH; m++) x_in[m+1] = $signed(bus.peripheral_samples_in[m]);
    end

`ifdef MIC_DC_BLOCK_EN
    // dc holds the running mean in Q(SAMPLE_WIDTH).8; squaring uses the estimate from before this sample.
    logic signed [SAMPLE_WIDTH+7:0] dc [NUM_MICS];

    function automatic logic signed [D_W-1:0] dc_remove(input logic signed [SAMPLE_WIDTH-1:0] x,
                                                        input logic signed [SAMPLE_WIDTH+7:0] dc_q);
        logic signed [SAMPLE_WIDTH+7:0] dc_int;
        dc_int = dc_q >>> 8;
        return $signed({x[SAMPLE_WIDTH-1], x}) - $signed(dc_int[SAMPLE_WIDTH:0]);
    endfunction

    function automatic logic signed [SAMPLE_WIDTH+7:0] dc_next(input logic signed [SAMPLE_WIDTH-1:0] x,
                                                               input logic signed [SAMPLE_WIDTH+7:0] dc_q);
        logic signed [SAMPLE_WIDTH+8:0] diff;
        diff = $signed({x[SAMPLE_WIDTH-1], x, 8'd0}) - $signed({dc_q[SAMPLE_WIDTH+7], dc_q});
        diff = diff >>> 8;
        return $signed(dc_q + diff[SAMPLE_WIDTH+7:0]);
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int m = 0; m < NUM_MICS; m++) dc[m] <= '0;
        end else if (bus.sample_valid_in) begin
            for (int m = 0; m < NUM_MICS; m++) dc[m] <= dc_next(x_in[m], dc[m]);
        end
    end

    always_comb begin
        for (int m = 0; m < NUM_MICS; m++) d_in[m] = dc_remove(x_in[m], dc[m]);
    end
`else
    always_comb begin
        for (int m = 0; m < NUM_MICS; m++) d_in[m] = x_in[m];
    end
`endif

    // Stage 1: square
    logic [SQ_W-1:0] sq_p1 [NUM_MICS];
    logic            vld_p1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p1 <= 1'b0;
            for (int m = 0; m < NUM_MICS; m++) sq_p1[m] <= '0;
        end else begin
            vld_p1 <= bus.sample_valid_in;
            if (bus.sample_valid_in) begin
                for (int m = 0; m < NUM_MICS; m++) sq_p1[m] <= square(d_in[m]);
            end
        end
    end

    // Stage 2: accumulate, close window, publish energies
    logic [ACC_W-1:0]       acc_p2    [NUM_MICS];
    logic [31:0]            energy_p2 [NUM_MICS];
    logic [WINDOW_LOG2-1:0] cnt_p2;
    logic                   vld_p2;
    logic                   close_p1;

    assign close_p1 = vld_p1 && (cnt_p2 == LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p2 <= 1'b0;
            cnt_p2 <= '0;
            for (int m = 0; m < NUM_MICS; m++) begin
                acc_p2[m]    <= '0;
                energy_p2[m] <= '0;
            end
        end else begin
            vld_p2 <= close_p1;
            if (vld_p1) begin
                cnt_p2 <= cnt_p2 + WINDOW_LOG2'(1);
                for (int m = 0; m < NUM_MICS; m++) begin
                    // The closing sample belongs to the finished window, so the next one starts empty.
                    if (close_p1) begin
                        energy_p2[m] <= sat_energy(acc_p2[m] + ACC_W'(sq_p1[m]));
                        acc_p2[m]    <= '0;
                    end else begin
                        acc_p2[m]    <= acc_p2[m] + ACC_W'(sq_p1[m]);
                    end
                end
            end
        end
    end

    assign bus.central_energy_out = energy_p2[0];
    assign bus.energy_valid_out   = vld_p2;
    assign bus.window_count_out   = cnt_p2;

    always_comb begin
        for (int m = 0; m < NUM_PERIPH; m++) bus.peripheral_energy_out[m] = energy_p2[m+1];
    end
endmodule

// File: tb/tb_mic_energy_accumulator.sv
// Bench for mic_energy_accumulator: two instances (window 4 and window 1024) share one stimulus
// stream and are compared every cycle against a window-sum reference model.
module tb_mic_energy_accumulator;
    localparam int SW = 16;
    localparam int NP = 3;
    localparam int WL [2] = '{2, 10};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic                     s_vld = 1'b0;
    logic [SW-1:0]            s_c   = '0;
    logic [NP-1:0][SW-1:0]    s_p   = '0;

    mic_energy_if #(.SAMPLE_WIDTH(SW), .NUM_PERIPH(NP), .WINDOW_LOG2(2))  if_s ();
    mic_energy_if #(.SAMPLE_WIDTH(SW), .NUM_PERIPH(NP), .WINDOW_LOG2(10)) if_b ();

    assign if_s.sample_valid_in       = s_vld;
    assign if_s.central_sample_in     = s_c;
    assign if_s.peripheral_samples_in = s_p;
    assign if_b.sample_valid_in       = s_vld;
    assign if_b.central_sample_in     = s_c;
    assign if_b.peripheral_samples_in = s_p;

    mic_energy_accumulator #(.SAMPLE_WIDTH(SW), .NUM_PERIPH(NP), .WINDOW_LOG2(2)) u_small (
        .clk_in(clk), .rst_n_in(rst_n), .bus(if_s.slave));
    mic_energy_accumulator #(.SAMPLE_WIDTH(SW), .NUM_PERIPH(NP), .WINDOW_LOG2(10)) u_big (
        .clk_in(clk), .rst_n_in(rst_n), .bus(if_b.slave));

    logic [31:0] obs_e [2][4];
    logic        obs_v [2];
    logic [31:0] obs_c [2];

    always_comb begin
        obs_v[0] = if_s.energy_valid_out;
        obs_v[1] = if_b.energy_valid_out;
        obs_c[0] = 32'(if_s.window_count_out);
        obs_c[1] = 32'(if_b.window_count_out);
        obs_e[0][0] = if_s.central_energy_out;
        obs_e[1][0] = if_b.central_energy_out;
        for (int m = 0; m < NP; m++) begin
            obs_e[0][m+1] = if_s.peripheral_energy_out[m];
            obs_e[1][m+1] = if_b.peripheral_energy_out[m];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: per-window sums of squares, mean by shift, clip to 32 bits.
    longint sum   [2][4];
    int     cnt   [2];
    longint exp_e [2][4];
    longint pend  [2][4];
    bit     close_prev [2];
    longint dc [4];

    function automatic longint sat32(input longint v);
        return (v > 64'sh0000_0000_FFFF_FFFF) ? 64'sh0000_0000_FFFF_FFFF : v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0;
            close_prev[i] = 1'b0;
            for (int m = 0; m < 4; m++) begin
                sum[i][m] = 0; exp_e[i][m] = 0; pend[i][m] = 0;
            end
        end
        for (int m = 0; m < 4; m++) dc[m] = 0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_vld%0d", tag, i), 64'(obs_v[i]), 64'(close_prev[i]));
            chk($sformatf("%s_cnt%0d", tag, i), 64'(obs_c[i]), 64'(cnt[i]));
            for (int m = 0; m < 4; m++)
                chk($sformatf("%s_e%0d_%0d", tag, i, m), 64'(obs_e[i][m]), exp_e[i][m]);
        end
    endtask

    task automatic step(input bit v, input logic signed [SW-1:0] c, input logic signed [SW-1:0] p0,
                        input logic signed [SW-1:0] p1, input logic signed [SW-1:0] p2);
        longint x [4];
        longint dsq [4];
        longint d;
        bit close_now [2];
        @(negedge clk);
        s_vld = v; s_c = c; s_p[0] = p0; s_p[1] = p1; s_p[2] = p2;
        x[0] = longint'(c); x[1] = longint'(p0); x[2] = longint'(p1); x[3] = longint'(p2);
        for (int i = 0; i < 2; i++) begin
            close_now[i] = 1'b0;
            if (close_prev[i]) for (int m = 0; m < 4; m++) exp_e[i][m] = pend[i][m];
        end
        @(posedge clk);
        #1;
        check_all("step");
        if (v) begin
            for (int m = 0; m < 4; m++) begin
`ifdef MIC_DC_BLOCK_EN
                d = x[m] - (dc[m] >>> 8);
                dc[m] = dc[m] + ((x[m] * 256 - dc[m]) >>> 8);
`else
                d = x[m];
`endif
                dsq[m] = d * d;
            end
            for (int i = 0; i < 2; i++) begin
                for (int m = 0; m < 4; m++) sum[i][m] += dsq[m];
                cnt[i]++;
                if (cnt[i] == (1 << WL[i])) begin
                    for (int m = 0; m < 4; m++) begin
                        pend[i][m] = sat32(sum[i][m] >>> WL[i]);
                        sum[i][m] = 0;
                    end
                    cnt[i] = 0;
                    close_now[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) close_prev[i] = close_now[i];
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_async_vld%0d", i), 64'(obs_v[i]), 64'd0);
            chk($sformatf("rst_async_cnt%0d", i), 64'(obs_c[i]), 64'd0);
            for (int m = 0; m < 4; m++)
                chk($sformatf("rst_async_e%0d_%0d", i, m), 64'(obs_e[i][m]), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk($sformatf("rst_hold_vld%0d", i), 64'(obs_v[i]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    function automatic logic signed [SW-1:0] rnd_sample();
        case ($urandom_range(0, 7))
            0:       return 16'sh8000;
            1:       return 16'sh7FFF;
            2:       return 16'sh0000;
            default: return SW'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        do_reset();

        // Constant 4 on every mic for one small window
        for (int k = 0; k < 4; k++) step(1'b1, 16'sd4, 16'sd4, 16'sd4, 16'sd4);
        idle(1);
        chk("const4_central", 64'(obs_e[0][0]), 64'd16);
        chk("const4_periph2", 64'(obs_e[0][3]), 64'd16);
        chk("const4_pulse",   64'(obs_v[0]),    64'd1);

        // Alternating-sign central sequence: (1+4+9+16)>>2 = 7
        step(1'b1, 16'sd1,  '0, '0, '0);
        step(1'b1, -16'sd2, '0, '0, '0);
        step(1'b1, 16'sd3,  '0, '0, '0);
        step(1'b1, -16'sd4, '0, '0, '0);
        idle(1);
        chk("alt_central", 64'(obs_e[0][0]), 64'd7);
        chk("alt_periph0", 64'(obs_e[0][1]), 64'd0);

        // Gapped strobes, one every third cycle
        for (int k = 0; k < 8; k++) begin
            idle(2);
            step(1'b1, 16'sd8, 16'sd8, 16'sd8, 16'sd8);
        end
        idle(1);
        chk("gap_central", 64'(obs_e[0][0]), 64'd64);
        chk("gap_periph1", 64'(obs_e[0][2]), 64'd64);
        idle(3);
        chk("gap_hold", 64'(obs_e[0][0]), 64'd64);
        for (int k = 0; k < 4; k++) begin
            idle(2);
            step(1'b1, '0, '0, '0, '0);
        end
        idle(1);
        chk("gap_zero", 64'(obs_e[0][0]), 64'd0);

        // Random samples and random strobe pattern
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 9) < 7, rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());

        // Mid-stream reset discards the partial window
        do_reset();
        idle(2);

        // Most negative sample for one full big window, strobe continuous
        for (int k = 0; k < 1024; k++) step(1'b1, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000);
        idle(1);
        chk("extreme_big", 64'(obs_e[1][0]), 64'h4000_0000);
        chk("extreme_small", 64'(obs_e[0][3]), 64'h4000_0000);

        // Constant DC input over four big windows
        for (int k = 0; k < 4096; k++) step(1'b1, 16'sd100, 16'sd100, 16'sd100, 16'sd100);
        idle(2);
`ifdef MIC_DC_BLOCK_EN
        chk("dc_removed", 64'(obs_e[1][0] < 32'd4), 64'd1);
`else
        chk("dc_kept", 64'(obs_e[1][0]), 64'd10000);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
